apb_uart_rx: RTL and testbench
==============================

APB_UART_RX -- requirements
Module: apb_uart_rx

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, APB data width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit; minimum 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, RX FIFO entries; power of two, maximum 8.
REQ-004 SHALL have port clk input 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset input 1, synchronous active-high reset.
REQ-006 SHALL have port S_PADDR input 2, register select: 0 = DATA, 1 = STATUS, 2-3 unused.
REQ-007 SHALL have port S_PWRITE input 1, APB write strobe.
REQ-008 SHALL have port S_PSELx input 1, APB select.
REQ-009 SHALL have port S_PENABLE input 1, APB access phase.
REQ-010 SHALL have port S_PWDATA input BUS_WIDTH, APB write data.
REQ-011 SHALL have port S_PRDATA output BUS_WIDTH, APB read data.
REQ-012 SHALL have port S_PREADY output 1, APB ready.
REQ-013 SHALL have port rx_wire input 1, asynchronous serial line, idle high.
REQ-014 SHALL have port irq output 1, high while RX FIFO non-empty.

Function
REQ-015 SHALL pass rx_wire through a 2-flop synchronizer; all receive logic uses the synchronized value rx_s.
REQ-016 SHALL implement receive FSM states IDLE, START, DATA, STOP with a bit-timer counter and a 3-bit bit index.
REQ-017 IDLE SHALL go to START when rx_s = 0, clearing the bit timer.
REQ-018 START SHALL sample rx_s after CLKS_PER_BIT/2 cycles: 0 -> DATA; 1 -> IDLE (glitch rejected, no flag set).
REQ-019 DATA SHALL sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first into a shift register, then go to STOP.
REQ-020 STOP SHALL sample rx_s after CLKS_PER_BIT cycles: 1 -> push byte; 0 -> discard byte and set sticky frame_err; then IDLE in both cases.
REQ-021 A push with FIFO full and no same-cycle pop SHALL drop the byte and set sticky overrun; FIFO contents SHALL be unchanged.
REQ-022 A push and a pop in the same cycle SHALL both complete, count unchanged; when full, no overrun is set.
REQ-023 A pushed byte SHALL be visible in count/irq the cycle after the stop-bit sample.
REQ-024 apb_sel = S_PSELx & S_PENABLE; a transfer completes on the cycle apb_sel & S_PREADY.
REQ-025 DATA read: S_PREADY = apb_sel & !empty (wait states while empty); S_PRDATA = {zeros, head byte}; exactly one pop on the completing cycle.
REQ-026 STATUS read: S_PREADY = apb_sel; S_PRDATA[3:0] = count, [4] = empty, [5] = full, [6] = overrun, [7] = frame_err, [8] = busy (FSM not IDLE), other bits 0.
REQ-027 STATUS write: S_PREADY = apb_sel; S_PWDATA[6] = 1 clears overrun and S_PWDATA[7] = 1 clears frame_err on the completing cycle; a same-cycle set wins over the clear.
REQ-028 DATA write and any access to address 2-3: S_PREADY = apb_sel, no state change, S_PRDATA = 0.
REQ-029 When apb_sel = 0, S_PRDATA SHALL be 0 and S_PREADY 0.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-031 Reset SHALL force FSM to IDLE, FIFO empty (count 0), overrun = 0, frame_err = 0, irq = 0, synchronizer flops = 1.
REQ-032 Reset mid-frame SHALL abandon the partial byte; the next start bit after reset release SHALL be received normally.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 8)
REQ-033 Send 0xA5 (8N1), then APB read DATA -> PRDATA = 0x00A5, one pop, STATUS then reads count 0, empty 1, irq 0.
REQ-034 APB read DATA with FIFO empty, then send 0x3C -> PREADY held low until push, then transfer completes with PRDATA = 0x003C.
REQ-035 Send 9 bytes 0x01..0x09 with no reads -> STATUS = full 1, count 8, overrun 1; eight DATA reads return 0x01..0x08; write STATUS 0x0040 -> overrun 0.
REQ-036 Send 0x55 with stop bit 0 -> no push, frame_err 1, count 0; then 0x66 with a valid stop bit -> received normally.
REQ-037 Low pulse of 4 cycles on rx_wire -> FSM returns to IDLE, no push, no flags set.
REQ-038 Assert reset during the DATA bit 4 of 0x81 -> count 0 and flags 0 after reset; next frame 0x7E is read back as 0x007E.

Source files
------------

// File: rtl/apb_uart_rx_if.sv
// ---------------------------------------------------------------------------
// apb_uart_rx_if
// Bundles the APB slave bus of the UART receiver so the bus travels as one
// port instead of seven loose wires.
//
// Signals
//   S_PADDR    2-bit register select (0 = DATA, 1 = STATUS, 2-3 unused)
//   S_PWRITE   write strobe
//   S_PSELx    peripheral select
//   S_PENABLE  access phase
//   S_PWDATA   write data, BUS_WIDTH bits
//   S_PRDATA   read data, BUS_WIDTH bits
//   S_PREADY   transfer ready
//
// Modports
//   master     the bus initiator (testbench or bridge)
//   slave      the UART receiver
// ---------------------------------------------------------------------------
interface apb_uart_rx_if #(
   parameter int BUS_WIDTH = 16
);
   logic [1:0]           S_PADDR;
   logic                 S_PWRITE;
   logic                 S_PSELx;
   logic                 S_PENABLE;
   logic [BUS_WIDTH-1:0] S_PWDATA;
   logic [BUS_WIDTH-1:0] S_PRDATA;
   logic                 S_PREADY;

   modport master (
      output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
      input  S_PRDATA, S_PREADY
   );

   modport slave (
      input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
      output S_PRDATA, S_PREADY
   );
endinterface

// File: rtl/apb_uart_rx.sv
// ---------------------------------------------------------------------------
// apb_uart_rx
// 8N1 UART receiver with a small RX FIFO, read and controlled over APB.
//
// Ports
//   clk      sole clock, rising edge
//   reset    synchronous active-high reset
//   apb      APB slave bus (apb_uart_rx_if.slave)
//   rx_wire  asynchronous serial input, idle high
//   irq      high while the RX FIFO holds at least one byte
//
// Registers
//   addr 0 DATA   read pops the head byte (waits while FIFO is empty)
//   addr 1 STATUS [3:0] count, [4] empty, [5] full, [6] overrun,
//                 [7] frame_err, [8] busy; write 1 to bit 6/7 to clear
// ---------------------------------------------------------------------------
module apb_uart_rx #(
   parameter int BUS_WIDTH    = 16,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          reset,
   apb_uart_rx_if.slave  apb,
   input  logic          rx_wire,
   output logic          irq
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] LAST_P = PW'(FIFO_DEPTH - 1);
   localparam logic [3:0]    DEPTH_C = 4'(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          rxMeta_q, rxSync_q;
   logic [1:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [3:0]    count_q, count_d;
   logic          overrun_q, overrun_d, frameErr_q, frameErr_d;

   logic pushReq, frameSet, pushDo, pop, overrunSet;
   logic empty, full, apbSel, isDataRd, isStatusRd, isStatusWr;
   logic [BUS_WIDTH-1:0] statusWord, dataWord;
   logic unusedPwdata;

   assign empty = (count_q == 4'd0);
   assign full  = (count_q == DEPTH_C);
   assign irq   = !empty;

   assign apbSel     = apb.S_PSELx & apb.S_PENABLE;
   assign isDataRd   = apbSel & !apb.S_PWRITE & (apb.S_PADDR == 2'd0);
   assign isStatusRd = apbSel & !apb.S_PWRITE & (apb.S_PADDR == 2'd1);
   assign isStatusWr = apbSel &  apb.S_PWRITE & (apb.S_PADDR == 2'd1);

   // A DATA read only completes once a byte is available, and that is the
   // cycle the head byte leaves the FIFO.
   assign pop = isDataRd & !empty;

   // A byte arriving into a full FIFO still fits if the head is leaving in
   // the same cycle; otherwise it is dropped and flagged as an overrun.
   assign pushDo     = pushReq & (!full | pop);
   assign overrunSet = pushReq & full & !pop;

   assign unusedPwdata = ^apb.S_PWDATA;

   // Two-flop synchronizer for the asynchronous serial line. Both flops
   // reset to the idle level so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
      end else begin
         rxMeta_q <= rx_wire;
         rxSync_q <= rxMeta_q;
      end
   end

   // Receive state machine. START waits half a bit to land in the middle of
   // the start bit, so every later sample, one full bit apart, also lands
   // mid-bit. A line that is high again at that point was only a glitch.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      pushReq  = 1'b0;
      frameSet = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxSync_q) begin
               state_d = START;
               timer_d = '0;
            end
         end
         START: begin
            if (timer_q == HALF_T) begin
               timer_d = '0;
               idx_d   = 3'd0;
               state_d = rxSync_q ? IDLE : DATA;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DATA: begin
            if (timer_q == FULL_T) begin
               timer_d = '0;
               shift_d = {rxSync_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            if (timer_q == FULL_T) begin
               timer_d  = '0;
               state_d  = IDLE;
               pushReq  = rxSync_q;
               frameSet = !rxSync_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
      endcase
   end

   // FIFO bookkeeping and the two sticky error flags. When a flag is set
   // and cleared in the same cycle, the new error is kept.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      overrun_d  = overrun_q;
      frameErr_d = frameErr_q;
      if (pushDo) begin
         wrPtr_d = (wrPtr_q == LAST_P) ? '0 : wrPtr_q + 1'b1;
      end
      if (pop) begin
         rdPtr_d = (rdPtr_q == LAST_P) ? '0 : rdPtr_q + 1'b1;
      end
      if (pushDo && !pop) begin
         count_d = count_q + 4'd1;
      end else if (pop && !pushDo) begin
         count_d = count_q - 4'd1;
      end
      if (isStatusWr && apb.S_PWDATA[6]) begin
         overrun_d = 1'b0;
      end
      if (isStatusWr && apb.S_PWDATA[7]) begin
         frameErr_d = 1'b0;
      end
      if (overrunSet) begin
         overrun_d = 1'b1;
      end
      if (frameSet) begin
         frameErr_d = 1'b1;
      end
   end

   // State registers. Reset drops any partially received byte and empties
   // the FIFO by rewinding both pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         idx_q      <= 3'd0;
         shift_q    <= 8'd0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= 4'd0;
         overrun_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         frameErr_q <= frameErr_d;
      end
   end

   // FIFO storage has no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (pushDo) begin
         mem_q[wrPtr_q] <= shift_q;
      end
   end

   // Read-data mux and ready. Only a DATA read can stall; every other
   // access completes in its first access-phase cycle.
   always_comb begin
      statusWord      = '0;
      statusWord[3:0] = count_q;
      statusWord[4]   = empty;
      statusWord[5]   = full;
      statusWord[6]   = overrun_q;
      statusWord[7]   = frameErr_q;
      statusWord[8]   = (state_q != IDLE);
      dataWord        = '0;
      dataWord[7:0]   = mem_q[rdPtr_q];
      apb.S_PRDATA    = '0;
      apb.S_PREADY    = isDataRd ? !empty : apbSel;
      if (pop) begin
         apb.S_PRDATA = dataWord;
      end else if (isStatusRd) begin
         apb.S_PRDATA = statusWord;
      end
   end

endmodule

// File: tb/tb_apb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_apb_uart_rx
// Directed bench for apb_uart_rx with CLKS_PER_BIT = 16 and FIFO_DEPTH = 8.
// Serial frames are driven bit by bit, registers are accessed over APB, and
// every result is compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_apb_uart_rx;

   localparam int CPB = 16;
   localparam int BW  = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rxWire = 1'b1;
   logic irq;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   logic [15:0] rdData;
   int          waited;

   apb_uart_rx_if #(.BUS_WIDTH(BW)) apbIf ();

   apb_uart_rx #(
      .BUS_WIDTH   (BW),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .apb    (apbIf.slave),
      .rx_wire(rxWire),
      .irq    (irq)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Advance n rising edges and step just past the last one, so inputs
   // change and outputs are sampled away from the active edge.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the serial line at one level for a number of clock cycles.
   task automatic applyStimulus(input logic level, input int cycles);
      rxWire = level;
      waitCycles(cycles);
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
      end
   endtask

   // One 8N1 frame followed by a bit time of idle line.
   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      applyStimulus(1'b0, CPB);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(b[i], CPB);
      end
      applyStimulus(stopBit, CPB);
      applyStimulus(1'b1, CPB);
   endtask

   // APB read with a bounded wait; data stays X if the slave never answers.
   task automatic apbRead(input logic [1:0] addr, input int budget,
                          output logic [15:0] data, output int waitCount);
      data      = 'x;
      waitCount = 0;
      apbIf.S_PADDR   = addr;
      apbIf.S_PWRITE  = 1'b0;
      apbIf.S_PSELx   = 1'b1;
      apbIf.S_PENABLE = 1'b0;
      waitCycles(1);
      apbIf.S_PENABLE = 1'b1;
      #1;
      while (!apbIf.S_PREADY && waitCount < budget) begin
         waitCycles(1);
         #1;
         waitCount++;
      end
      if (apbIf.S_PREADY) begin
         data = apbIf.S_PRDATA;
      end
      waitCycles(1);
      apbIf.S_PSELx   = 1'b0;
      apbIf.S_PENABLE = 1'b0;
   endtask

   // APB write; every write completes in its first access-phase cycle.
   task automatic apbWrite(input logic [1:0] addr, input logic [15:0] data);
      apbIf.S_PADDR   = addr;
      apbIf.S_PWRITE  = 1'b1;
      apbIf.S_PWDATA  = data;
      apbIf.S_PSELx   = 1'b1;
      apbIf.S_PENABLE = 1'b0;
      waitCycles(1);
      apbIf.S_PENABLE = 1'b1;
      waitCycles(1);
      apbIf.S_PSELx   = 1'b0;
      apbIf.S_PENABLE = 1'b0;
      apbIf.S_PWRITE  = 1'b0;
   endtask

   task automatic checkStatus(input string tag, input logic [15:0] expected);
      logic [15:0] s;
      int          w;
      apbRead(2'd1, 4, s, w);
      checkOutput(tag, s, expected);
   endtask

   task automatic checkData(input string tag, input logic [15:0] expected);
      logic [15:0] d;
      int          w;
      apbRead(2'd0, 4, d, w);
      checkOutput(tag, d, expected);
   endtask

   // Directed sequence covering reset, normal reception, stalled reads,
   // overrun, framing error, glitch rejection and reset mid-frame.
   initial begin
      apbIf.S_PADDR   = 2'd0;
      apbIf.S_PWRITE  = 1'b0;
      apbIf.S_PSELx   = 1'b0;
      apbIf.S_PENABLE = 1'b0;
      apbIf.S_PWDATA  = '0;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(2);

      checkOutput("resetIrq", {15'd0, irq}, 16'h0000);
      checkOutput("idlePrdata", apbIf.S_PRDATA, 16'h0000);
      checkStatus("resetStatus", 16'h0010);

      // Single byte, then read it back and confirm the FIFO drained.
      sendByte(8'hA5, 1'b1);
      checkOutput("irqAfterA5", {15'd0, irq}, 16'h0001);
      checkStatus("statusOneByte", 16'h0001);
      checkData("dataA5", 16'h00A5);
      checkStatus("statusDrained", 16'h0010);
      checkOutput("irqDrained", {15'd0, irq}, 16'h0000);

      // Read issued on an empty FIFO must stall until the byte arrives.
      fork
         apbRead(2'd0, 400, rdData, waited);
         sendByte(8'h3C, 1'b1);
      join
      checkOutput("stalledData", rdData, 16'h003C);
      checkOutput("stallLong", {15'd0, (waited > 100)}, 16'h0001);
      checkStatus("statusAfterStall", 16'h0010);

      // Nine bytes into an eight-deep FIFO: the ninth overruns.
      for (int i = 1; i <= 9; i++) begin
         sendByte(8'(i), 1'b1);
      end
      checkStatus("statusOverrun", 16'h0068);
      for (int i = 1; i <= 8; i++) begin
         checkData($sformatf("fifoData%0d", i), 16'(i));
      end
      checkStatus("statusEmptyOvr", 16'h0050);
      apbWrite(2'd1, 16'h0040);
      checkStatus("statusOvrCleared", 16'h0010);

      // Bad stop bit: byte discarded and frame error raised.
      sendByte(8'h55, 1'b0);
      applyStimulus(1'b1, 2 * CPB);
      checkStatus("statusFrameErr", 16'h0090);
      sendByte(8'h66, 1'b1);
      checkData("data66", 16'h0066);
      checkStatus("statusFrameSticky", 16'h0090);
      apbWrite(2'd1, 16'h0080);
      checkStatus("statusFrameCleared", 16'h0010);

      // A short low pulse is not a start bit.
      applyStimulus(1'b0, 4);
      applyStimulus(1'b1, 3 * CPB);
      checkStatus("statusGlitch", 16'h0010);
      checkOutput("irqGlitch", {15'd0, irq}, 16'h0000);

      // Put 0x81 on the line, reset during data bit 4, then send 0x7E.
      applyStimulus(1'b0, CPB);
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i == 0) ? 1'b1 : 1'b0, CPB);
      end
      rxWire = 1'b0;
      checkStatus("statusBusy", 16'h0110);
      waitCycles(4);
      reset  = 1'b1;
      rxWire = 1'b1;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(2 * CPB);
      checkStatus("statusAfterReset", 16'h0010);
      sendByte(8'h7E, 1'b1);
      checkData("data7E", 16'h007E);
      checkStatus("statusFinal", 16'h0010);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
